// File: rtl/box_draw_arbiter.sv
// box_draw_arbiter
// Round-robin share of a single box drawer between three box sources
// (0 = left paddle, 1 = right paddle, 2 = ball). Each granted request
// produces an optional erase beat (previous rectangle in BG_COLOR) and
// then a draw beat (new rectangle in its own colour).
module box_draw_arbiter #(
    parameter int                 COORD_W  = 9,
    parameter int                 COLOR_W  = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear_hist,
    input  logic [2:0]             req_valid,
    output logic [2:0]             req_ready,
    input  logic [3*COORD_W-1:0]   req_x,
    input  logic [3*COORD_W-1:0]   req_y,
    input  logic [3*COORD_W-1:0]   req_w,
    input  logic [3*COORD_W-1:0]   req_h,
    input  logic [3*COLOR_W-1:0]   req_color,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [COORD_W-1:0]     m_x,
    output logic [COORD_W-1:0]     m_y,
    output logic [COORD_W-1:0]     m_w,
    output logic [COORD_W-1:0]     m_h,
    output logic [COLOR_W-1:0]     m_color,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Per-source views of the packed request buses (source i at [i*W +: W]).
    logic [2:0][COORD_W-1:0] src_x, src_y, src_w, src_h;
    logic [2:0][COLOR_W-1:0] src_c;

    assign src_x = req_x;
    assign src_y = req_y;
    assign src_w = req_w;
    assign src_h = req_h;
    assign src_c = req_color;

    // Arbitration
    logic [1:0] last_grant_q;
    logic [1:0] grant_q;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       grant_found;
    logic       transfer;
    logic       same_box;
    logic       skip_erase;
    logic       beat_done;

    // Previously drawn box per source
    logic [2:0]              have_prev_q;
    logic [2:0][COORD_W-1:0] prev_x_q, prev_y_q, prev_w_q, prev_h_q;

    // Working copy of the accepted request
    logic [COORD_W-1:0] cap_x_q, cap_y_q, cap_w_q, cap_h_q;
    logic [COLOR_W-1:0] cap_c_q;

    // Registered beat towards the drawer
    logic               m_valid_q;
    logic [COORD_W-1:0] m_x_q, m_y_q, m_w_q, m_h_q;
    logic [COLOR_W-1:0] m_color_q;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Round-robin search starting just after the last granted source.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = next_src(last_grant_q);
        for (int k = 0; k < 3; k++) begin
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = next_src(cand);
        end
    end

    assign transfer   = (state_q == S_IDLE) && grant_found;
    assign same_box   = (src_x[grant_idx] == prev_x_q[grant_idx]) &&
                        (src_y[grant_idx] == prev_y_q[grant_idx]) &&
                        (src_w[grant_idx] == prev_w_q[grant_idx]) &&
                        (src_h[grant_idx] == prev_h_q[grant_idx]);
    // Nothing to erase if the source never drew, or the rectangle is unchanged.
    assign skip_erase = !have_prev_q[grant_idx] || same_box;
    assign beat_done  = m_valid_q && m_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (transfer)  state_d = skip_erase ? S_DRAW : S_ERASE;
            S_ERASE: if (beat_done) state_d = S_DRAW;
            S_DRAW:  if (beat_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the current grant
    always_comb begin
        req_ready = 3'b000;
        if (transfer) begin
            req_ready = 3'b001 << grant_idx;
        end
        busy = (state_q != S_IDLE);
    end

    // Capture the granted request and remember who was served last.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_x_q      <= '0;
            cap_y_q      <= '0;
            cap_w_q      <= '0;
            cap_h_q      <= '0;
            cap_c_q      <= '0;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd2;
        end else if (transfer) begin
            cap_x_q      <= src_x[grant_idx];
            cap_y_q      <= src_y[grant_idx];
            cap_w_q      <= src_w[grant_idx];
            cap_h_q      <= src_h[grant_idx];
            cap_c_q      <= src_c[grant_idx];
            grant_q      <= grant_idx;
            last_grant_q <= grant_idx;
        end
    end

    // Load the beat registers on entry to ERASE/DRAW; hold while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_x_q     <= '0;
            m_y_q     <= '0;
            m_w_q     <= '0;
            m_h_q     <= '0;
            m_color_q <= '0;
        end else if (transfer) begin
            m_valid_q <= 1'b1;
            if (skip_erase) begin
                m_x_q     <= src_x[grant_idx];
                m_y_q     <= src_y[grant_idx];
                m_w_q     <= src_w[grant_idx];
                m_h_q     <= src_h[grant_idx];
                m_color_q <= src_c[grant_idx];
            end else begin
                m_x_q     <= prev_x_q[grant_idx];
                m_y_q     <= prev_y_q[grant_idx];
                m_w_q     <= prev_w_q[grant_idx];
                m_h_q     <= prev_h_q[grant_idx];
                m_color_q <= BG_COLOR;
            end
        end else if (state_q == S_ERASE && beat_done) begin
            m_x_q     <= cap_x_q;
            m_y_q     <= cap_y_q;
            m_w_q     <= cap_w_q;
            m_h_q     <= cap_h_q;
            m_color_q <= cap_c_q;
        end else if (state_q == S_DRAW && beat_done) begin
            m_valid_q <= 1'b0;
        end
    end

    // Record the drawn box per source; a same-edge clear_hist takes priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            have_prev_q <= '0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            prev_w_q    <= '0;
            prev_h_q    <= '0;
        end else begin
            if (state_q == S_DRAW && beat_done) begin
                prev_x_q[grant_q]    <= cap_x_q;
                prev_y_q[grant_q]    <= cap_y_q;
                prev_w_q[grant_q]    <= cap_w_q;
                prev_h_q[grant_q]    <= cap_h_q;
                have_prev_q[grant_q] <= 1'b1;
            end
            if (clear_hist) begin
                have_prev_q <= '0;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_x     = m_x_q;
    assign m_y     = m_y_q;
    assign m_w     = m_w_q;
    assign m_h     = m_h_q;
    assign m_color = m_color_q;

endmodule

// File: tb/tb_box_draw_arbiter.sv
// Bench for box_draw_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a beat-queue model.
module tb_box_draw_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear_hist;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [26:0] req_x, req_y, req_w, req_h;
    logic [8:0]  req_color;
    logic        m_valid;
    logic        m_ready;
    logic [8:0]  m_x, m_y, m_w, m_h;
    logic [2:0]  m_color;
    logic        busy;

    logic [8:0] sx [3];
    logic [8:0] sy [3];
    logic [8:0] sw [3];
    logic [8:0] sh [3];
    logic [2:0] sc [3];

    int checks = 0;
    int errors = 0;

    box_draw_arbiter dut (
        .clock(clock), .reset(reset), .clear_hist(clear_hist),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .req_color(req_color),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_x(m_x), .m_y(m_y), .m_w(m_w), .m_h(m_h), .m_color(m_color),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always_comb begin
        req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_color = '0;
        for (int i = 0; i < 3; i++) begin
            req_x[i*9 +: 9]     = sx[i];
            req_y[i*9 +: 9]     = sy[i];
            req_w[i*9 +: 9]     = sw[i];
            req_h[i*9 +: 9]     = sh[i];
            req_color[i*3 +: 3] = sc[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [8:0] x, y, w, h;
        logic [2:0] c;
        bit         is_draw;
        int         src;
    } beat_t;

    beat_t      pend[$];
    int         last_g = 2;
    bit         have[3] = '{0, 0, 0};
    logic [8:0] px[3] = '{0, 0, 0};
    logic [8:0] py[3] = '{0, 0, 0};
    logic [8:0] pw[3] = '{0, 0, 0};
    logic [8:0] ph[3] = '{0, 0, 0};

    function automatic int m_grant();
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last_g + k) % 3;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pend.delete();
            last_g = 2;
            for (int i = 0; i < 3; i++) begin
                have[i] = 0; px[i] = 0; py[i] = 0; pw[i] = 0; ph[i] = 0;
            end
        end else begin
            if (pend.size() == 0) begin
                int g;
                g = m_grant();
                if (g >= 0) begin
                    beat_t b;
                    bit skip;
                    skip = !have[g] || (sx[g] == px[g] && sy[g] == py[g] &&
                                        sw[g] == pw[g] && sh[g] == ph[g]);
                    if (!skip) begin
                        b = '{x: px[g], y: py[g], w: pw[g], h: ph[g], c: 3'b000, is_draw: 0, src: g};
                        pend.push_back(b);
                    end
                    b = '{x: sx[g], y: sy[g], w: sw[g], h: sh[g], c: sc[g], is_draw: 1, src: g};
                    pend.push_back(b);
                    last_g = g;
                end
            end else if (m_ready) begin
                beat_t b;
                b = pend.pop_front();
                if (b.is_draw) begin
                    px[b.src] = b.x; py[b.src] = b.y; pw[b.src] = b.w; ph[b.src] = b.h;
                    have[b.src] = 1;
                end
            end
            if (clear_hist) begin
                for (int i = 0; i < 3; i++) have[i] = 0;
            end
        end
    end

    // ---------------- per-cycle compare and monitors ----------------
    int   grant_log[$];
    logic [44:0] beat_log[$];
    int   rr0_cnt  = 0;
    int   busy_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            logic [2:0] exp_rr;
            int g;
            exp_rr = 3'b000;
            g = m_grant();
            if (pend.size() == 0 && g >= 0) exp_rr = 3'(1 << g);
            chk("req_ready", req_ready, exp_rr);
            chk("req_ready_onehot", $countones(req_ready) <= 1, 1);
            chk("busy", busy, pend.size() != 0);
            chk("m_valid", m_valid, pend.size() != 0);
            if (pend.size() != 0) begin
                chk("m_beat", {m_x, m_y, m_w, m_h, m_color},
                    {pend[0].x, pend[0].y, pend[0].w, pend[0].h, pend[0].c});
            end
            if (req_ready != 0) grant_log.push_back(req_ready[0] ? 0 : (req_ready[1] ? 1 : 2));
            if (m_valid && m_ready) beat_log.push_back({m_x, m_y, m_w, m_h, m_color});
            if (req_ready[0]) rr0_cnt++;
            if (busy) busy_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_src(input int s, input int x, input int y, input int w, input int h, input int c);
        sx[s] = 9'(x); sy[s] = 9'(y); sw[s] = 9'(w); sh[s] = 9'(h); sc[s] = 3'(c);
    endtask

    task automatic send(input int s, input int x, input int y, input int w, input int h, input int c);
        int n;
        @(posedge clock); #1;
        set_src(s, x, y, w, h, c);
        req_valid[s] = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready[s] && n < 100);
        if (!req_ready[s]) chk("grant_timeout", 0, 1);
        @(posedge clock); #1;
        req_valid[s] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy && n < 200);
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    function automatic logic [44:0] bx(input int x, input int y, input int w, input int h, input int c);
        return {9'(x), 9'(y), 9'(w), 9'(h), 3'(c)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] acc;
        bit         sent[3];
        reset = 1'b1; clear_hist = 1'b0; req_valid = 3'b000; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_src(i, 0, 0, 0, 0, 0);
            sent[i] = 0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset values
        @(negedge clock);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_m_beat", {m_x, m_y, m_w, m_h, m_color}, 0);

        // First request after reset: draw only
        beat_log.delete(); rr0_cnt = 0; busy_cnt = 0;
        send(0, 0, 96, 10, 48, 7);
        wait_idle();
        chk("t1_beats", beat_log.size(), 1);
        if (beat_log.size() >= 1) chk("t1_draw", beat_log[0], bx(0, 96, 10, 48, 7));
        chk("t1_ready_pulses", rr0_cnt, 1);
        chk("t1_busy_cycles", busy_cnt, 1);

        // Same source moved: erase old, draw new
        beat_log.delete();
        send(0, 0, 100, 10, 48, 7);
        wait_idle();
        chk("t2_beats", beat_log.size(), 2);
        if (beat_log.size() >= 2) begin
            chk("t2_erase", beat_log[0], bx(0, 96, 10, 48, 0));
            chk("t2_draw", beat_log[1], bx(0, 100, 10, 48, 7));
        end

        // All three valid: rotation 0,1,2,0,1,2
        do_reset();
        set_src(0, 10, 20, 5, 5, 1);
        set_src(1, 30, 40, 6, 6, 2);
        set_src(2, 50, 60, 7, 7, 3);
        grant_log.delete();
        req_valid = 3'b111;
        for (int n = 0; n < 200 && grant_log.size() < 6; n++) @(negedge clock);
        @(posedge clock); #1;
        req_valid = 3'b000;
        wait_idle();
        chk("t3_grants", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("t3_order", grant_log[i], i % 3);

        // Stall the erase beat for five cycles
        @(posedge clock); #1;
        m_ready = 1'b0;
        set_src(1, 31, 41, 6, 6, 4);
        req_valid = 3'b010;
        @(posedge clock); #1;
        req_valid = 3'b000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t4_hold_valid", m_valid, 1);
            chk("t4_hold_beat", {m_x, m_y, m_w, m_h, m_color}, bx(30, 40, 6, 6, 0));
        end
        @(posedge clock); #1;
        m_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("t4_draw_valid", m_valid, 1);
        chk("t4_draw_beat", {m_x, m_y, m_w, m_h, m_color}, bx(31, 41, 6, 6, 4));
        wait_idle();

        // clear_hist then ball at new position: draw only
        @(posedge clock); #1 clear_hist = 1'b1;
        @(posedge clock); #1 clear_hist = 1'b0;
        beat_log.delete();
        send(2, 100, 110, 7, 7, 5);
        wait_idle();
        chk("t5_beats", beat_log.size(), 1);
        if (beat_log.size() >= 1) chk("t5_draw", beat_log[0], bx(100, 110, 7, 7, 5));

        // Reset during DRAW (colour-only change goes straight to DRAW)
        @(posedge clock); #1;
        m_ready = 1'b0;
        set_src(2, 100, 110, 7, 7, 6);
        req_valid = 3'b100;
        @(posedge clock); #1;
        req_valid = 3'b000;
        @(negedge clock);
        chk("t6_draw_color", {m_valid, m_color}, {1'b1, 3'd6});
        #2 reset = 1'b1;
        #1;
        chk("t6_abort_valid", m_valid, 0);
        chk("t6_abort_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        m_ready = 1'b1;
        beat_log.delete();
        send(2, 120, 130, 7, 7, 2);
        wait_idle();
        chk("t6_beats", beat_log.size(), 1);
        if (beat_log.size() >= 1) chk("t6_draw", beat_log[0], bx(120, 130, 7, 7, 2));

        // Random traffic against the model
        for (int cyc = 0; cyc < 3050; cyc++) begin
            @(negedge clock);
            acc = req_valid & req_ready;
            @(posedge clock); #1;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && cyc < 3000 && $urandom_range(3) == 0) begin
                    if (!(sent[i] && $urandom_range(1) == 0)) begin
                        sx[i] = 9'($urandom); sy[i] = 9'($urandom);
                        sw[i] = 9'($urandom); sh[i] = 9'($urandom);
                    end
                    sc[i] = 3'($urandom);
                    sent[i] = 1;
                    req_valid[i] = 1'b1;
                end
            end
            m_ready    = (cyc >= 3000) || ($urandom_range(9) < 7);
            clear_hist = (cyc < 3000) && ($urandom_range(39) == 0);
        end
        clear_hist = 1'b0;
        m_ready = 1'b1;
        wait_idle();
        chk("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
